// File: rtl/fft_out_reorder.sv
// fft_out_reorder: ping-pong buffer that turns an FFT/IFFT output stream
// written in arbitrary index order into a natural-order valid/ready stream.
module fft_out_reorder #(
  parameter int TOTAL_STAGE_P = 6,
  parameter int MULT_WIDTH_P  = 18
) (
  input  logic                     iclk,
  input  logic                     rst,
  input  logic                     ien,
  input  logic [TOTAL_STAGE_P-1:0] iaddr,
  input  logic [MULT_WIDTH_P-1:0]  iReal,
  input  logic [MULT_WIDTH_P-1:0]  iImag,
  input  logic                     iready,
  output logic                     ovalid,
  output logic [TOTAL_STAGE_P-1:0] oaddr,
  output logic [MULT_WIDTH_P-1:0]  oReal,
  output logic [MULT_WIDTH_P-1:0]  oImag,
  output logic                     olast,
  output logic                     oovf
);

  localparam int DEPTH = 1 << TOTAL_STAGE_P;
  localparam int DW    = 2 * MULT_WIDTH_P;

  logic [DW-1:0]            r_mem [0:2*DEPTH-1];
  logic [1:0]               r_full;
  logic                     r_wr_bank;
  logic [TOTAL_STAGE_P-1:0] r_wr_cnt;
  logic                     r_rd_bank;
  logic                     r_pf_bank;
  logic                     r_pf_valid;
  logic [TOTAL_STAGE_P-1:0] r_rd_cnt;
  logic [TOTAL_STAGE_P-1:0] r_pf_addr;
  logic [DW-1:0]            r_pf_data;

  logic       w_wr_ok;
  logic       w_wr_done;
  logic       w_xfer;
  logic       w_rel;
  logic       w_out_ld;
  logic       w_pf_ld;
  logic [1:0] w_set;
  logic [1:0] w_clr;

  assign w_wr_ok   = ien & ~r_full[r_wr_bank];
  assign w_wr_done = w_wr_ok & (&r_wr_cnt);
  assign w_xfer    = ovalid & iready;
  assign w_rel     = w_xfer & olast;
  // Output register refills whenever it is empty or being drained.
  assign w_out_ld  = r_pf_valid & (~ovalid | iready);
  // Prefetch stage reads the next entry of a full bank into its register.
  assign w_pf_ld   = r_full[r_pf_bank] & (~r_pf_valid | w_out_ld);
  assign w_set     = {r_wr_bank & w_wr_done, ~r_wr_bank & w_wr_done};
  assign w_clr     = {r_rd_bank & w_rel, ~r_rd_bank & w_rel};

  // Sample storage and prefetch read register; contents are never reset.
  always_ff @(posedge iclk) begin
    if (w_wr_ok) begin
      r_mem[{r_wr_bank, iaddr}] <= {iReal, iImag};
    end
    if (w_pf_ld) begin
      r_pf_data <= r_mem[{r_pf_bank, r_rd_cnt}];
    end
  end

  // Write side: frame counting, bank full flags and sticky overflow.
  always_ff @(posedge iclk or posedge rst) begin
    if (rst) begin
      r_full    <= '0;
      r_wr_bank <= 1'b0;
      r_wr_cnt  <= '0;
      oovf      <= 1'b0;
    end else begin
      r_full <= (r_full | w_set) & ~w_clr;
      if (ien && r_full[r_wr_bank]) begin
        oovf <= 1'b1;
      end
      if (w_wr_ok) begin
        r_wr_cnt <= r_wr_cnt + TOTAL_STAGE_P'(1);
        if (w_wr_done) begin
          r_wr_bank <= ~r_wr_bank;
        end
      end
    end
  end

  // Prefetch side: walks a full bank in natural order, one entry ahead.
  always_ff @(posedge iclk or posedge rst) begin
    if (rst) begin
      r_pf_bank  <= 1'b0;
      r_rd_cnt   <= '0;
      r_pf_valid <= 1'b0;
      r_pf_addr  <= '0;
    end else if (w_pf_ld) begin
      r_pf_valid <= 1'b1;
      r_pf_addr  <= r_rd_cnt;
      r_rd_cnt   <= r_rd_cnt + TOTAL_STAGE_P'(1);
      if (&r_rd_cnt) begin
        r_pf_bank <= ~r_pf_bank;
      end
    end else if (w_out_ld) begin
      r_pf_valid <= 1'b0;
    end
  end

  // Registered output stage; the bank is released on its last transfer.
  always_ff @(posedge iclk or posedge rst) begin
    if (rst) begin
      ovalid    <= 1'b0;
      oaddr     <= '0;
      oReal     <= '0;
      oImag     <= '0;
      olast     <= 1'b0;
      r_rd_bank <= 1'b0;
    end else begin
      if (w_out_ld) begin
        ovalid         <= 1'b1;
        oaddr          <= r_pf_addr;
        {oReal, oImag} <= r_pf_data;
        olast          <= &r_pf_addr;
      end else if (w_xfer) begin
        ovalid <= 1'b0;
        olast  <= 1'b0;
      end
      if (w_rel) begin
        r_rd_bank <= ~r_rd_bank;
      end
    end
  end

endmodule

// File: tb/tb_fft_out_reorder.sv
// tb_fft_out_reorder: directed scenarios for the FFT output reorder
// buffer with an 8-point frame and 18-bit samples.
module tb_fft_out_reorder;

  localparam int N = 3;
  localparam int W = 18;

  logic         iclk = 1'b0;
  logic         rst;
  logic         ien;
  logic [N-1:0] iaddr;
  logic [W-1:0] iReal;
  logic [W-1:0] iImag;
  logic         iready;
  logic         ovalid;
  logic [N-1:0] oaddr;
  logic [W-1:0] oReal;
  logic [W-1:0] oImag;
  logic         olast;
  logic         oovf;

  int checks = 0;
  int errors = 0;
  int br[8] = '{0, 4, 2, 6, 1, 5, 3, 7};

  fft_out_reorder #(
    .TOTAL_STAGE_P(N),
    .MULT_WIDTH_P (W)
  ) dut (
    .iclk  (iclk),
    .rst   (rst),
    .ien   (ien),
    .iaddr (iaddr),
    .iReal (iReal),
    .iImag (iImag),
    .iready(iready),
    .ovalid(ovalid),
    .oaddr (oaddr),
    .oReal (oReal),
    .oImag (oImag),
    .olast (olast),
    .oovf  (oovf)
  );

  always #5 iclk = ~iclk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  task automatic wr(input int a, input int re, input int im);
    @(negedge iclk);
    ien   = 1'b1;
    iaddr = N'(a);
    iReal = W'(re);
    iImag = W'(im);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge iclk);
      ien = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst    = 1'b1;
    ien    = 1'b0;
    iaddr  = '0;
    iReal  = '0;
    iImag  = '0;
    iready = 1'b1;
    @(negedge iclk);
    @(negedge iclk);
    checks++;
    if (ovalid !== 1'b0) begin
      errors++;
      $display("FAIL reset_ovalid: got %b want 0", ovalid);
    end
    checks++;
    if (olast !== 1'b0 || oovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: olast %b oovf %b want 0 0", olast, oovf);
    end
    checks++;
    if (oaddr !== 3'd0 || oReal !== 18'd0 || oImag !== 18'd0) begin
      errors++;
      $display("FAIL reset_data: addr %0d re %0d im %0d want 0 0 0",
               oaddr, oReal, oImag);
    end
    rst = 1'b0;
  endtask

  task automatic test_bitrev;
    for (int i = 0; i < 8; i++) wr(br[i], br[i] * 3, -br[i]);
    idle(1);
    checks++;
    if (ovalid !== 1'b0) begin
      errors++;
      $display("FAIL bitrev_lat1: ovalid %b want 0", ovalid);
    end
    idle(1);
    checks++;
    if (ovalid !== 1'b0) begin
      errors++;
      $display("FAIL bitrev_lat2: ovalid %b want 0", ovalid);
    end
    idle(1);
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (ovalid !== 1'b1 || oaddr !== N'(k) || oReal !== W'(k * 3) ||
          oImag !== W'(-k) || olast !== (k == 7)) begin
        errors++;
        $display("FAIL bitrev_k%0d: v %b a %0d re %0d im %h last %b want 1 %0d %0d %h %b",
                 k, ovalid, oaddr, oReal, oImag, olast,
                 k, k * 3, W'(-k), k == 7);
      end
      idle(1);
    end
    checks++;
    if (ovalid !== 1'b0) begin
      errors++;
      $display("FAIL bitrev_end: ovalid %b want 0", ovalid);
    end
  endtask

  task automatic test_backpressure;
    int t;
    int k;
    int stall;
    int hold3;
    for (int i = 0; i < 8; i++) wr(i, 100 + i, i);
    t = 0;
    while (ovalid !== 1'b1 && t < 10) begin
      idle(1);
      t++;
    end
    checks++;
    if (t != 3) begin
      errors++;
      $display("FAIL bp_latency: got %0d cycles want 3", t);
    end
    k = 0;
    stall = 0;
    hold3 = 0;
    for (int c = 0; c < 40 && k < 8; c++) begin
      checks++;
      if (ovalid !== 1'b1 || oaddr !== N'(k) || oReal !== W'(100 + k) ||
          oImag !== W'(k) || olast !== (k == 7)) begin
        errors++;
        $display("FAIL bp_k%0d: v %b a %0d re %0d im %0d last %b want 1 %0d %0d %0d %b",
                 k, ovalid, oaddr, oReal, oImag, olast,
                 k, 100 + k, k, k == 7);
      end
      if (oaddr == 3'd3) hold3++;
      if (k == 3 && stall < 5) begin
        iready = 1'b0;
        stall++;
      end else begin
        iready = 1'b1;
        k++;
      end
      @(negedge iclk);
    end
    iready = 1'b1;
    checks++;
    if (k != 8 || hold3 != 6) begin
      errors++;
      $display("FAIL bp_count: samples %0d hold %0d want 8 6", k, hold3);
    end
    checks++;
    if (ovalid !== 1'b0) begin
      errors++;
      $display("FAIL bp_end: ovalid %b want 0", ovalid);
    end
  endtask

  task automatic test_pingpong;
    int j;
    int gap;
    int bad;
    j = 0;
    gap = 0;
    bad = 0;
    fork
      begin
        for (int f = 0; f < 3; f++) begin
          for (int i = 0; i < 8; i++) wr(br[i], (f + 1) * 100 + br[i], f);
          idle(1);
        end
      end
      begin
        for (int c = 0; c < 120 && j < 24; c++) begin
          @(negedge iclk);
          if (ovalid === 1'b1) begin
            checks++;
            if (oaddr !== N'(j % 8) || oReal !== W'((j / 8 + 1) * 100 + j % 8) ||
                oImag !== W'(j / 8) || olast !== (j % 8 == 7)) begin
              errors++;
              $display("FAIL pp_j%0d: a %0d re %0d im %0d last %b want %0d %0d %0d %b",
                       j, oaddr, oReal, oImag, olast, j % 8,
                       (j / 8 + 1) * 100 + j % 8, j / 8, j % 8 == 7);
            end
            if (j > 0 && gap > ((j % 8 == 0) ? 1 : 0)) bad++;
            gap = 0;
            j++;
          end else begin
            gap++;
          end
        end
      end
    join
    idle(2);
    checks++;
    if (j != 24 || bad != 0) begin
      errors++;
      $display("FAIL pp_stream: samples %0d bad gaps %0d want 24 0", j, bad);
    end
    checks++;
    if (oovf !== 1'b0 || ovalid !== 1'b0) begin
      errors++;
      $display("FAIL pp_end: oovf %b ovalid %b want 0 0", oovf, ovalid);
    end
  endtask

  task automatic test_overflow;
    int j;
    iready = 1'b0;
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 8; i++) wr(7 - i, 200 + f * 10 + 7 - i, f + 5);
    end
    idle(1);
    checks++;
    if (oovf !== 1'b0) begin
      errors++;
      $display("FAIL ovf_before: oovf %b want 0", oovf);
    end
    wr(0, 999, 9);
    idle(1);
    checks++;
    if (oovf !== 1'b1) begin
      errors++;
      $display("FAIL ovf_first_drop: oovf %b want 1", oovf);
    end
    for (int i = 1; i < 8; i++) wr(i, 999, 9);
    idle(1);
    checks++;
    if (ovalid !== 1'b1 || oaddr !== 3'd0 || oReal !== 18'd200) begin
      errors++;
      $display("FAIL ovf_hold: v %b a %0d re %0d want 1 0 200",
               ovalid, oaddr, oReal);
    end
    iready = 1'b1;
    j = 0;
    for (int c = 0; c < 40 && j < 16; c++) begin
      if (ovalid === 1'b1) begin
        checks++;
        if (oaddr !== N'(j % 8) || oReal !== W'(200 + (j / 8) * 10 + j % 8) ||
            oImag !== W'(j / 8 + 5) || olast !== (j % 8 == 7)) begin
          errors++;
          $display("FAIL ovf_j%0d: a %0d re %0d im %0d last %b want %0d %0d %0d %b",
                   j, oaddr, oReal, oImag, olast, j % 8,
                   200 + (j / 8) * 10 + j % 8, j / 8 + 5, j % 8 == 7);
        end
        j++;
      end
      @(negedge iclk);
    end
    idle(3);
    checks++;
    if (j != 16 || ovalid !== 1'b0 || oovf !== 1'b1) begin
      errors++;
      $display("FAIL ovf_end: samples %0d ovalid %b oovf %b want 16 0 1",
               j, ovalid, oovf);
    end
  endtask

  task automatic test_midreset;
    int t;
    for (int i = 0; i < 5; i++) wr(i, 0, 0);
    @(negedge iclk);
    ien = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if (ovalid !== 1'b0 || oovf !== 1'b0) begin
      errors++;
      $display("FAIL mr_partial: ovalid %b oovf %b want 0 0", ovalid, oovf);
    end
    @(negedge iclk);
    rst   = 1'b0;
    ien   = 1'b1;
    iaddr = 3'd0;
    iReal = 18'd300;
    iImag = 18'd1;
    for (int i = 1; i < 8; i++) wr(i, 300 + i, 1);
    t = 0;
    while (ovalid !== 1'b1 && t < 10) begin
      idle(1);
      t++;
    end
    checks++;
    if (t != 3) begin
      errors++;
      $display("FAIL mr_first_frame: latency %0d want 3", t);
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (ovalid !== 1'b1 || oaddr !== N'(k) || oReal !== W'(300 + k)) begin
        errors++;
        $display("FAIL mr_k%0d: v %b a %0d re %0d want 1 %0d %0d",
                 k, ovalid, oaddr, oReal, k, 300 + k);
      end
      if (k < 2) @(negedge iclk);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (ovalid !== 1'b0 || oaddr !== 3'd0 || oReal !== 18'd0 || olast !== 1'b0) begin
      errors++;
      $display("FAIL mr_readout: v %b a %0d re %0d last %b want 0 0 0 0",
               ovalid, oaddr, oReal, olast);
    end
    @(negedge iclk);
    rst = 1'b0;
    idle(4);
    checks++;
    if (ovalid !== 1'b0) begin
      errors++;
      $display("FAIL mr_discard: ovalid %b want 0", ovalid);
    end
    for (int i = 0; i < 8; i++) wr(br[i], 400 + br[i], 2);
    idle(3);
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (ovalid !== 1'b1 || oaddr !== N'(k) || oReal !== W'(400 + k) ||
          oImag !== 18'd2 || olast !== (k == 7)) begin
        errors++;
        $display("FAIL mr_clean_k%0d: v %b a %0d re %0d im %0d last %b want 1 %0d %0d 2 %b",
                 k, ovalid, oaddr, oReal, oImag, olast, k, 400 + k, k == 7);
      end
      idle(1);
    end
  endtask

  task automatic test_dup_addr;
    int t;
    int da[8] = '{2, 0, 1, 3, 4, 2, 5, 6};
    int dr[8] = '{10, 700, 701, 703, 704, 20, 705, 706};
    int er;
    int ei;
    @(negedge iclk);
    rst = 1'b1;
    @(negedge iclk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) wr(i, 500 + i, 0);
    idle(12);
    for (int i = 0; i < 8; i++) wr(i, 600 + i, 1);
    idle(12);
    for (int i = 0; i < 8; i++) wr(da[i], dr[i], 7);
    t = 0;
    while (ovalid !== 1'b1 && t < 10) begin
      idle(1);
      t++;
    end
    checks++;
    if (t != 3) begin
      errors++;
      $display("FAIL dup_latency: got %0d want 3", t);
    end
    for (int k = 0; k < 8; k++) begin
      er = (k == 2) ? 20 : (k == 7) ? 507 : 700 + k;
      ei = (k == 7) ? 0 : 7;
      checks++;
      if (ovalid !== 1'b1 || oaddr !== N'(k) || oReal !== W'(er) ||
          oImag !== W'(ei)) begin
        errors++;
        $display("FAIL dup_k%0d: v %b a %0d re %0d im %0d want 1 %0d %0d %0d",
                 k, ovalid, oaddr, oReal, oImag, k, er, ei);
      end
      idle(1);
    end
  endtask

  initial begin
    test_reset;
    test_bitrev;
    test_backpressure;
    test_pingpong;
    test_overflow;
    test_midreset;
    test_dup_addr;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft_out_reorder.md
FFT_OUT_REORDER -- requirements
Module: fft_out_reorder

Interface
REQ-001 The block SHALL have parameter TOTAL_STAGE_P, default 6, meaning log2 of the frame length; legal range 3 to 11.
REQ-002 The block SHALL have parameter MULT_WIDTH_P, default 18, meaning the width of each real and imaginary sample; legal values 9 and 18.
REQ-003 The block SHALL have port iclk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port ien, input, 1 bit: write strobe from the FFT/IFFT output stream.
REQ-006 The block SHALL have port iaddr, input, TOTAL_STAGE_P bits: frequency or time index of the write, in arbitrary order.
REQ-007 The block SHALL have ports iReal and iImag, input, MULT_WIDTH_P bits each: the write sample.
REQ-008 The block SHALL have port iready, input, 1 bit: the downstream accepts the output sample.
REQ-009 The block SHALL have port ovalid, output, 1 bit: an output sample is presented.
REQ-010 The block SHALL have port oaddr, output, TOTAL_STAGE_P bits: natural-order index of the presented sample.
REQ-011 The block SHALL have ports oReal and oImag, output, MULT_WIDTH_P bits each: the presented sample.
REQ-012 The block SHALL have port olast, output, 1 bit: high with ovalid when oaddr equals 2^TOTAL_STAGE_P-1.
REQ-013 The block SHALL have port oovf, output, 1 bit: sticky overflow flag, high when a write was dropped.

Function
REQ-014 Storage SHALL be two banks (ping-pong) of 2^TOTAL_STAGE_P entries, each entry 2*MULT_WIDTH_P bits.
REQ-015 Each bank SHALL carry a full flag; the write side owns one bank (wr_bank) and the read side owns the other (rd_bank).
REQ-016 On a cycle with ien=1 and wr_bank not full, the block SHALL store {iReal,iImag} at entry iaddr of wr_bank and increment a write counter.
REQ-017 The write counter SHALL count writes, not distinct addresses; duplicate iaddr within a frame overwrites, and the last value wins.
REQ-018 When the write counter reaches 2^TOTAL_STAGE_P on a write, the block SHALL set the bank full flag, toggle wr_bank, and clear the counter in the same edge.
REQ-019 On a cycle with ien=1 and wr_bank full, the block SHALL drop the sample, leave the counter unchanged, and set oovf.
REQ-020 oovf SHALL clear only on reset.
REQ-021 The read side SHALL present the entries of a full rd_bank in order oaddr = 0,1,…,2^TOTAL_STAGE_P-1.
REQ-022 Outputs ovalid, oaddr, oReal, oImag and olast SHALL be registered.
REQ-023 ovalid SHALL rise exactly 2 cycles after the clock edge that performed the final write of a frame, when the read side is idle.
REQ-024 A transfer SHALL occur on a cycle with ovalid=1 and iready=1.
REQ-025 While ovalid=1 and iready=0, oaddr, oReal, oImag and olast SHALL hold stable.
REQ-026 With iready held high, the block SHALL deliver one sample per cycle with no bubbles inside a frame.
REQ-027 On the transfer with olast=1, the block SHALL clear that bank's full flag, toggle rd_bank, and wrap the read counter to 0.
REQ-028 If the other bank is already full at that transfer, the next frame SHALL start back-to-back or with at most a 1-cycle ovalid gap.
REQ-029 A write completion and a read release in the same cycle SHALL both take effect.
REQ-030 A bank released by the reader SHALL be writable on the next cycle.

Reset
REQ-031 rst=1 SHALL asynchronously force ovalid=0, olast=0, oovf=0, oaddr=0, oReal=0 and oImag=0.
REQ-032 rst=1 SHALL asynchronously clear both full flags, the write counter and the read counter, and set wr_bank=0 and rd_bank=0.
REQ-033 Memory contents SHALL NOT be reset.
REQ-034 Reset mid-frame SHALL discard partial and pending frames.
REQ-035 After rst deasserts, the first write SHALL be accepted on the first rising edge.

Verification
REQ-036 Scenario, bit-reversed frame: with TOTAL_STAGE_P=3, write 8 samples with iaddr 0,4,2,6,1,5,3,7 and data iReal=iaddr*3, iImag=-iaddr, iready=1 -> ovalid rises 2 cycles after the 8th write, oaddr runs 0..7 on consecutive cycles, oReal=0,3,…,21, and olast is high only at oaddr=7.
REQ-037 Scenario, backpressure: during readout, iready=0 for 5 cycles at oaddr=3 -> outputs hold oaddr=3 and the same data for 5 cycles, the sequence resumes at 4, and no sample is lost or duplicated.
REQ-038 Scenario, ping-pong: write 3 frames back-to-back with iready=1 -> 24 samples out in order, at most 1 idle cycle between frames, and oovf=0.
REQ-039 Scenario, overflow: with iready=0, write 3 full frames -> frames 1 and 2 fill both banks, all 8 writes of frame 3 are dropped, and oovf=1 from the first dropped write; then iready=1 -> frames 1 and 2 are output intact.
REQ-040 Scenario, mid-frame reset: assert rst after 5 writes and also during a readout at oaddr=2 -> ovalid=0 immediately, oovf=0, and a following clean 8-write frame outputs correctly starting at oaddr=0.
REQ-041 Scenario, duplicate address: within one frame write iaddr=2 twice, first with iReal=10 and then with iReal=20, plus 6 other addresses -> output at oaddr=2 has iReal=20, and the address never written holds stale memory.
